// File: rtl/fp_div_if.sv
// fp_div_if: operand/result bundle for the sequential FP divider.
//
// Handshake: the requester raises start for one or more cycles with the
// operands valid; the divider samples start (and the operands) only while
// idle. busy is high from the cycle after acceptance until the result is
// registered. done is a one-cycle pulse in the cycle the result is first
// visible. Results and flags hold until the next operation completes.
interface fp_div_if;
   logic        start;
   logic        sa;
   logic        sb;
   logic [7:0]  ea;
   logic [7:0]  eb;
   logic [22:0] ma;
   logic [22:0] mb;
   logic [23:0] mq_out;
   logic        signbit;
   logic [7:0]  exponent;
   logic        busy;
   logic        done;
   logic        ovf;
   logic        unf;
   logic        dz;

   modport master (
      output start, sa, sb, ea, eb, ma, mb,
      input  mq_out, signbit, exponent, busy, done, ovf, unf, dz
   );

   modport slave (
      input  start, sa, sb, ea, eb, ma, mb,
      output mq_out, signbit, exponent, busy, done, ovf, unf, dz
   );
endinterface

// File: rtl/fp_div.sv
// fp_div: sequential single-precision divider on unpacked fields.
// 26-step restoring division of the 24-bit mantissas, one normalize/round
// cycle, fixed latency of 27 cycles from acceptance to done.
// Optional build macro: FP_DIV_ROUND_EN selects round-to-nearest-even;
// without it the quotient mantissa is truncated.
module fp_div (
   input  logic       clk,
   input  logic       rst_n,
   fp_div_if.slave    bus,
   output logic [1:0] state_dbg_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_NORM = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [24:0] rem_q, rem_d;
   logic [23:0] b_q, b_d;
   logic [25:0] quo_q, quo_d;
   logic        sign_q, sign_d;
   logic [7:0]  ea_q, ea_d;
   logic [7:0]  eb_q, eb_d;

   logic [23:0] mq_q, mq_d;
   logic        sgn_out_q, sgn_out_d;
   logic [7:0]  exp_q, exp_d;
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;
   logic        dz_q, dz_d;
   logic        done_q, done_d;

   logic        step_ge;
   logic [24:0] step_rem;

   logic [9:0]  e_base, e_norm, e_fin;
   logic [23:0] mant, mant_fin;
   logic [23:0] rs_mq;
   logic [7:0]  rs_exp;
   logic        rs_ovf, rs_unf, rs_dz;

`ifdef FP_DIV_ROUND_EN
   logic        guard, sticky;
   logic [24:0] mant_inc;
`else
   logic        unused_trunc;
   assign unused_trunc = quo_q[0];
`endif

   // One restoring step: compare, conditionally subtract.
   always_comb begin : div_step
      step_ge  = (rem_q >= {1'b0, b_q});
      step_rem = step_ge ? (rem_q - {1'b0, b_q}) : rem_q;
   end

   // Normalize the quotient, round (optional) and resolve special cases.
   always_comb begin : norm_result
      e_base   = {2'b00, ea_q} - {2'b00, eb_q} + 10'd127;
      mant     = quo_q[25:2];
      e_norm   = e_base;
      mant_fin = 24'h0;
      e_fin    = 10'h0;
      rs_mq    = 24'h0;
      rs_exp   = 8'h0;
      rs_ovf   = 1'b0;
      rs_unf   = 1'b0;
      rs_dz    = 1'b0;
      if (!quo_q[25]) begin
         mant   = quo_q[24:1];
         e_norm = e_base - 10'd1;
      end
`ifdef FP_DIV_ROUND_EN
      guard    = quo_q[25] ? quo_q[1] : quo_q[0];
      sticky   = (quo_q[25] & quo_q[0]) | (rem_q != 25'd0);
      mant_inc = {1'b0, mant} + 25'd1;
      mant_fin = mant;
      e_fin    = e_norm;
      if (guard & (sticky | mant[0])) begin
         if (mant_inc[24]) begin
            mant_fin = 24'h800000;
            e_fin    = e_norm + 10'd1;
         end else begin
            mant_fin = mant_inc[23:0];
         end
      end
`else
      mant_fin = mant;
      e_fin    = e_norm;
`endif
      if (eb_q == 8'h00) begin
         rs_dz  = 1'b1;
         rs_exp = 8'hFF;
         rs_mq  = (ea_q == 8'h00) ? 24'h400000 : 24'h0;
      end else if (ea_q == 8'h00) begin
         rs_exp = 8'h00;
      end else if ($signed(e_fin) > 10'sd254) begin
         rs_ovf = 1'b1;
         rs_exp = 8'hFF;
      end else if ($signed(e_fin) < 10'sd1) begin
         rs_unf = 1'b1;
      end else begin
         rs_exp = e_fin[7:0];
         rs_mq  = mant_fin;
      end
   end

   // Control FSM: accept in IDLE, 26 division steps, one result cycle.
   always_comb begin : next_state
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      b_d       = b_q;
      quo_d     = quo_q;
      sign_d    = sign_q;
      ea_d      = ea_q;
      eb_d      = eb_q;
      mq_d      = mq_q;
      sgn_out_d = sgn_out_q;
      exp_d     = exp_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               rem_d   = {2'b01, bus.ma};
               b_d     = {1'b1, bus.mb};
               quo_d   = 26'h0;
               sign_d  = bus.sa ^ bus.sb;
               ea_d    = bus.ea;
               eb_d    = bus.eb;
               cnt_d   = 5'd0;
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            quo_d = {quo_q[24:0], step_ge};
            rem_d = step_rem << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd25) begin
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            mq_d      = rs_mq;
            sgn_out_d = sign_q;
            exp_d     = rs_exp;
            ovf_d     = rs_ovf;
            unf_d     = rs_unf;
            dz_d      = rs_dz;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and result registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin : regs
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         rem_q     <= 25'h0;
         b_q       <= 24'h0;
         quo_q     <= 26'h0;
         sign_q    <= 1'b0;
         ea_q      <= 8'h0;
         eb_q      <= 8'h0;
         mq_q      <= 24'h0;
         sgn_out_q <= 1'b0;
         exp_q     <= 8'h0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         b_q       <= b_d;
         quo_q     <= quo_d;
         sign_q    <= sign_d;
         ea_q      <= ea_d;
         eb_q      <= eb_d;
         mq_q      <= mq_d;
         sgn_out_q <= sgn_out_d;
         exp_q     <= exp_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         dz_q      <= dz_d;
         done_q    <= done_d;
      end
   end

   assign bus.mq_out   = mq_q;
   assign bus.signbit  = sgn_out_q;
   assign bus.exponent = exp_q;
   assign bus.ovf      = ovf_q;
   assign bus.unf      = unf_q;
   assign bus.dz       = dz_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: randomized and directed bench for fp_div with an arithmetic
// reference model (integer long division of the scaled mantissas).
// Honours FP_DIV_ROUND_EN the same way the design build does.
module tb_fp_div;

   logic       clk;
   logic       rst_n;
   logic [1:0] state_dbg;

   fp_div_if dif ();

   fp_div u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (dif),
      .state_dbg_o (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   // packed expectation: {sign, exponent[7:0], mq[23:0], ovf, unf, dz}
   logic [35:0] exp_q[$];
   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Reference: quotient = floor(A * 2^25 / B) with A,B in [1,2) scaled by 2^23.
   function automatic logic [35:0] ref_div(input logic sa, input logic sb,
                                           input logic [7:0] ea, input logic [7:0] eb,
                                           input logic [22:0] ma, input logic [22:0] mb);
      logic        sgn;
      logic [63:0] num, den;
      logic [25:0] q;
      logic        rnz, g, s;
      logic [24:0] mant;
      int          e;
      sgn = sa ^ sb;
      if (eb == 8'h00)
         return {sgn, 8'hFF, (ea == 8'h00) ? 24'h400000 : 24'h0, 3'b001};
      if (ea == 8'h00)
         return {sgn, 8'h00, 24'h0, 3'b000};
      num = {40'b0, 1'b1, ma} << 25;
      den = {40'b0, 1'b1, mb};
      q   = 26'(num / den);
      rnz = ((num % den) != 64'd0);
      e   = int'(ea) - int'(eb) + 127;
      if (q[25]) begin
         mant = {1'b0, q[25:2]}; g = q[1]; s = q[0] | rnz;
      end else begin
         mant = {1'b0, q[24:1]}; g = q[0]; s = rnz; e = e - 1;
      end
`ifdef FP_DIV_ROUND_EN
      if (g && (s || mant[0])) begin
         mant = mant + 25'd1;
         if (mant[24]) begin
            mant = 25'h0800000;
            e = e + 1;
         end
      end
`else
      if (g && s) mant = mant;
`endif
      if (e > 254) return {sgn, 8'hFF, 24'h0, 3'b100};
      if (e < 1)   return {sgn, 8'h00, 24'h0, 3'b010};
      return {sgn, 8'(e), mant[23:0], 3'b000};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_ops(input logic sa, input logic sb, input logic [7:0] ea,
                            input logic [7:0] eb, input logic [22:0] ma, input logic [22:0] mb);
      dif.sa = sa; dif.sb = sb; dif.ea = ea; dif.eb = eb; dif.ma = ma; dif.mb = mb;
   endtask

   task automatic scramble_ops();
      logic [31:0] r1, r2;
      r1 = $urandom(); r2 = $urandom();
      drive_ops(r1[31], r2[31], r1[30:23], r2[30:23], r1[22:0], r2[22:0]);
   endtask

   task automatic compare_result(input string tag);
      logic [35:0] e;
      if (exp_q.size() == 0) begin
         check_val({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
         return;
      end
      e = exp_q.pop_front();
      check_val({tag, "_sign"}, 32'(dif.signbit), 32'(e[35]));
      check_val({tag, "_exp"},  32'(dif.exponent), 32'(e[34:27]));
      check_val({tag, "_mq"},   32'(dif.mq_out), 32'(e[26:3]));
      check_val({tag, "_ovf"},  32'(dif.ovf), 32'(e[2]));
      check_val({tag, "_unf"},  32'(dif.unf), 32'(e[1]));
      check_val({tag, "_dz"},   32'(dif.dz), 32'(e[0]));
      check_val({tag, "_busy"}, 32'(dif.busy), 32'd0);
   endtask

   // Called at the negedge after the accepting edge; counts edges to done.
   // inject >= 0 raises start with junk operands in that one cycle.
   task automatic wait_done(input int inject, output int n);
      n = 0;
      while (n < 40) begin
         if (n == inject) begin
            dif.start = 1'b1;
            scramble_ops();
         end else if (inject >= 0) begin
            dif.start = 1'b0;
         end
         @(posedge clk);
         n++;
         @(negedge clk);
         if (dif.done) break;
      end
      dif.start = 1'b0;
      check_val("done_seen", 32'(dif.done), 32'd1);
   endtask

   task automatic run_op(input string tag, input int inject, input logic sa, input logic sb,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic [22:0] ma, input logic [22:0] mb);
      int n;
      @(negedge clk);
      drive_ops(sa, sb, ea, eb, ma, mb);
      dif.start = 1'b1;
      exp_q.push_back(ref_div(sa, sb, ea, eb, ma, mb));
      @(posedge clk);
      @(negedge clk);
      dif.start = 1'b0;
      scramble_ops();
      check_val({tag, "_busy_hi"}, 32'(dif.busy), 32'd1);
      wait_done(inject, n);
      check_val({tag, "_latency"}, 32'(n), 32'd27);
      compare_result(tag);
      @(negedge clk);
      check_val({tag, "_done_fall"}, 32'(dif.done), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_mq"},    32'(dif.mq_out), 32'd0);
      check_val({tag, "_sign"},  32'(dif.signbit), 32'd0);
      check_val({tag, "_exp"},   32'(dif.exponent), 32'd0);
      check_val({tag, "_flags"}, 32'({dif.ovf, dif.unf, dif.dz}), 32'd0);
      check_val({tag, "_busy"},  32'(dif.busy), 32'd0);
      check_val({tag, "_done"},  32'(dif.done), 32'd0);
      check_val({tag, "_state"}, 32'(state_dbg), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          n;
      logic        saw_done;
      logic [31:0] r1, r2, r3;
      logic [7:0]  ea_r, eb_r;

      rst_n = 1'b0;
      dif.start = 1'b0;
      drive_ops(1'b0, 1'b0, 8'h0, 8'h0, 23'h0, 23'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // directed cases
      run_op("basic",    -1, 1'b0, 1'b1, 8'h81, 8'h82, 23'h200000, 23'h200000);
      run_op("norm",     -1, 1'b0, 1'b0, 8'h7F, 8'h7F, 23'h000000, 23'h400000);
      run_op("dz",       -1, 1'b1, 1'b0, 8'h80, 8'h00, 23'h123456, 23'h000000);
      run_op("dz00",     -1, 1'b0, 1'b0, 8'h00, 8'h00, 23'h000000, 23'h000000);
      run_op("zero",     -1, 1'b1, 1'b1, 8'h00, 8'h80, 23'h7FFFFF, 23'h000001);
      run_op("ovf",      -1, 1'b0, 1'b1, 8'hFE, 8'h01, 23'h000000, 23'h000000);
      run_op("unf",      -1, 1'b1, 1'b0, 8'h01, 8'hFE, 23'h000000, 23'h000000);
      run_op("max_mant", -1, 1'b0, 1'b0, 8'h90, 8'h70, 23'h7FFFFF, 23'h000000);
      run_op("min_edge", -1, 1'b0, 1'b0, 8'h01, 8'h7F, 23'h400000, 23'h000000);
      run_op("ovf_edge", -1, 1'b0, 1'b0, 8'hFE, 8'h7F, 23'h7FFFFF, 23'h7FFFFE);

      // start re-raised mid-operation is ignored
      run_op("ignore",    5, 1'b1, 1'b1, 8'h85, 8'h7A, 23'h3C0000, 23'h1A0000);

      // start held high through done: second op accepted in the done cycle
      @(negedge clk);
      drive_ops(1'b0, 1'b1, 8'h88, 8'h77, 23'h2AAAAA, 23'h555555);
      dif.start = 1'b1;
      exp_q.push_back(ref_div(1'b0, 1'b1, 8'h88, 8'h77, 23'h2AAAAA, 23'h555555));
      @(posedge clk);
      @(negedge clk);
      drive_ops(1'b1, 1'b1, 8'h60, 8'h90, 23'h0F0F0F, 23'h70F0F0);
      exp_q.push_back(ref_div(1'b1, 1'b1, 8'h60, 8'h90, 23'h0F0F0F, 23'h70F0F0));
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (dif.done) break;
      end
      check_val("b2b_first_done", 32'(dif.done), 32'd1);
      check_val("b2b_first_lat", 32'(n), 32'd27);
      compare_result("b2b_first");
      @(posedge clk);
      @(negedge clk);
      dif.start = 1'b0;
      scramble_ops();
      check_val("b2b_restart_busy", 32'(dif.busy), 32'd1);
      wait_done(-1, n);
      check_val("b2b_second_lat", 32'(n), 32'd27);
      compare_result("b2b_second");

      // reset in the middle of DIV
      @(negedge clk);
      drive_ops(1'b1, 1'b0, 8'h82, 8'h7E, 23'h111111, 23'h222222);
      dif.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dif.start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("midreset");
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (35) begin
         @(negedge clk);
         if (dif.done) saw_done = 1'b1;
      end
      check_val("no_done_after_reset", 32'(saw_done), 32'd0);
      run_op("post_reset", -1, 1'b0, 1'b0, 8'h80, 8'h7F, 23'h600000, 23'h200000);

      // randomized operands
      for (int i = 0; i < 200; i++) begin
         r1 = $urandom(); r2 = $urandom(); r3 = $urandom_range(0, 15);
         if (r3 < 10) begin
            ea_r = 8'($urandom_range(64, 190));
            eb_r = 8'($urandom_range(64, 190));
         end else begin
            ea_r = r1[30:23];
            eb_r = r2[30:23];
         end
         if (r3 == 14) ea_r = 8'h00;
         if (r3 == 15) eb_r = 8'h00;
         run_op("rand", -1, r1[31], r2[31], ea_r, eb_r, r1[22:0], r2[22:0]);
      end

      check_val("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
